// File: rtl/i_fetch_8bit.sv
// Instruction fetch initiator for a byte-wide SRAM with one-cycle registered reads.
// Each 16-bit instruction is built from two bytes, high byte at the even address.
module i_fetch_8bit #(
    parameter int MEM_DATA_WIDTH = 8,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int RESET_PC       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          redirect,
    input  logic [MEM_ADDR_WIDTH-1:0]     redirect_pc,
    input  logic                          ld_we,
    input  logic [MEM_ADDR_WIDTH-1:0]     ld_addr,
    input  logic [MEM_DATA_WIDTH-1:0]     ld_data,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    output logic                          mem_we,
    output logic [MEM_DATA_WIDTH-1:0]     mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_rdata,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [2*MEM_DATA_WIDTH-1:0]   instr,
    output logic [MEM_ADDR_WIDTH-1:0]     instr_pc,
    output logic                          busy
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = MEM_DATA_WIDTH;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HI   = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam logic [AW-1:0] PC_RESET = AW'(RESET_PC);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW-1:0] ADDR_TWO = AW'(2);

    logic [2:0]      state_q,       state_d;
    logic [AW-1:0]   pc_q,          pc_d;
    logic [DW-1:0]   hi_byte_q,     hi_byte_d;
    logic [2*DW-1:0] pend_q,        pend_d;
    logic [AW-1:0]   pend_pc_q,     pend_pc_d;
    logic [2*DW-1:0] instr_q,       instr_d;
    logic [AW-1:0]   instr_pc_q,    instr_pc_d;
    logic            instr_valid_q, instr_valid_d;

    logic [AW-1:0]   pc_plus1;
    logic [AW-1:0]   pc_plus2;
    logic [2*DW-1:0] word;
    logic            slot_free;
    logic [2:0]      resume_state;
    logic            unused_redirect_lsb;

    assign pc_plus1            = pc_q + ADDR_ONE;
    assign pc_plus2            = pc_q + ADDR_TWO;
    assign word                = {hi_byte_q, mem_rdata};
    assign slot_free           = !instr_valid_q || instr_ready;
    assign resume_state        = enable ? ST_HI : ST_IDLE;
    assign unused_redirect_lsb = redirect_pc[0];

    // SRAM port: loader owns it only while idle, fetch drives reads otherwise
    always_comb begin
        mem_addr  = pc_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (ld_we) begin
                    mem_addr  = ld_addr;
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                end
            end
            ST_LO,
            ST_CAP:  mem_addr = pc_plus1;
            default: mem_addr = pc_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hi_byte_d     = hi_byte_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        // A completed transfer empties the slot unless something refills it below
        if (instr_valid_q && instr_ready) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                state_d = ST_LO;
            end
            ST_LO: begin
                hi_byte_d = mem_rdata;
                state_d   = ST_CAP;
            end
            ST_CAP: begin
                pc_d = pc_plus2;
                if (slot_free) begin
                    instr_d       = word;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = resume_state;
                end else begin
                    pend_d    = word;
                    pend_pc_d = pc_q;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Slot is always valid here, so ready implies a transfer
                if (instr_ready) begin
                    instr_d       = pend_q;
                    instr_pc_d    = pend_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = resume_state;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect wins over any slot load and discards partial/pending words
        if (redirect) begin
            pc_d          = {redirect_pc[AW-1:1], 1'b0};
            hi_byte_d     = '0;
            pend_d        = '0;
            pend_pc_d     = '0;
            instr_valid_d = 1'b0;
            state_d       = resume_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= PC_RESET;
            hi_byte_q     <= '0;
            pend_q        <= '0;
            pend_pc_q     <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hi_byte_q     <= hi_byte_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/i_fetch_8bit.md
# i_fetch_8bit

Instruction fetch initiator for the 8-bit, 1024-byte instruction SRAM. It reads each 16-bit instruction as two consecutive bytes, high byte at the even address. The SRAM has a registered, one-cycle read latency. The block presents each instruction to the decode stage over a valid/ready handshake and accepts branch redirects. While fetch is disabled, it also muxes a test-bench/boot loader write port onto the SRAM.

## Interface
- MEM_DATA_WIDTH, 8, SRAM word width; instruction width is 2*MEM_DATA_WIDTH
- MEM_ADDR_WIDTH, 10, SRAM byte-address width
- RESET_PC, 0, fetch byte address after reset; must be even
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  1 = fetch runs; 0 = fetch stops after the current instruction
- redirect  input  1  one-cycle branch/jump request
- redirect_pc  input  MEM_ADDR_WIDTH  target byte address; bit 0 ignored
- ld_we  input  1  loader write strobe, honored only in IDLE
- ld_addr  input  MEM_ADDR_WIDTH  loader write address
- ld_data  input  MEM_DATA_WIDTH  loader write data
- mem_addr  output  MEM_ADDR_WIDTH  SRAM address, combinational from state
- mem_we  output  1  SRAM write enable
- mem_wdata  output  MEM_DATA_WIDTH  SRAM write data
- mem_rdata  input  MEM_DATA_WIDTH  SRAM registered read data
- instr_valid  output  1  instr/instr_pc hold a valid instruction
- instr_ready  input  1  decode accepts; transfer when valid&&ready at a rising edge
- instr  output  2*MEM_DATA_WIDTH  {byte[pc], byte[pc+1]}
- instr_pc  output  MEM_ADDR_WIDTH  byte address of instr
- busy  output  1  state != IDLE

## Operation
- Internal registers:
  - pc: even byte address.
  - hi_byte.
  - pend and pend_pc: one-entry overflow holding register.
  - Output slot: instr, instr_pc, instr_valid.
- States: IDLE, HI, LO, CAP, HOLD.
- IDLE:
  - mem_addr = ld_we ? ld_addr : pc.
  - mem_we = ld_we, mem_wdata = ld_data.
  - enable=1 -> HI. ld_we in the same cycle as enable is still written, and fetch starts next cycle.
- HI: mem_addr = pc. -> LO.
- LO: mem_addr = pc+1. hi_byte <= mem_rdata (byte at pc). -> CAP.
- CAP: mem_addr = pc+1. Assemble word = {hi_byte, mem_rdata}.
  - If the slot is free (instr_valid=0, or instr_ready=1 this cycle): load the slot with word/pc, then pc <= pc+2 -> HI if enable, else IDLE.
  - Otherwise: pend <= word, pend_pc <= pc, pc <= pc+2 -> HOLD.
- HOLD: mem_addr = pc.
  - When instr_ready=1: slot <= pend, then -> HI if enable, else IDLE.
- Outside IDLE: mem_we=0 and mem_wdata=0; ld_we is ignored and dropped.
- pc arithmetic is modulo 2^MEM_ADDR_WIDTH; 0x3FE+2 wraps to 0x000.
- Redirect, any state:
  - pc <= {redirect_pc[MSB:1],0}; hi_byte and pend are discarded.
  - instr_valid <= 0 next cycle. A transfer that completes in the redirect cycle counts as consumed.
  - Next state HI if enable, else IDLE.
  - Redirect overrides the CAP/HOLD slot load in the same cycle.
- enable deassertion in HI/LO/CAP/HOLD does not abort; the instruction in flight completes, then IDLE.
- Without a redirect, instr_valid drops only after a transfer. instr and instr_pc are stable while valid && !ready.

## Timing
- Reset values:
  - State IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, busy=0.
  - mem_we=0, mem_wdata=0, mem_addr=RESET_PC.
  - hi_byte=0, pend=0.
- Reset mid-operation returns to these values immediately, whatever the state.
- Fetch latency: enable rises in cycle 0 (IDLE). HI in cycle 1, LO in 2, CAP in 3, and instr_valid=1 in cycle 4.
- Throughput with ready held high: one instruction per 3 cycles (HI, LO, CAP).
- Redirect in cycle r: HI in r+1, first redirected instruction valid in r+4.
- HOLD absorbs one stalled instruction; fetch makes no further SRAM reads until the pending word moves to the slot.

## Test plan
- Load 0x12,0x34,0x56,0x78 at 0..3 via ld_we in IDLE, then enable with ready=1 -> instr 0x1234 @pc 0 valid in cycle 4, 0x5678 @pc 2 in cycle 7.
- instr_ready=0 for 10 cycles -> slot holds 0x1234; one pending word; state HOLD; mem_addr constant. Ready=1 -> words delivered in order, none lost or duplicated.
- Redirect to 0x101 (odd) while in LO with a valid slot -> valid drops next cycle; next instr_pc=0x100 = {byte[0x100], byte[0x101]}.
- Fetch from pc=0x3FE -> instr_pc 0x3FE delivered; next instr_pc 0x000.
- Drop enable in LO -> the current instruction is still delivered, then busy=0. ld_we pulsed while busy=1 -> memory unchanged.
- Assert rst_n low in CAP with instr_valid=1 -> all outputs at reset values immediately; restart fetches from RESET_PC.
